// File: rtl/mult_128.sv
// Iterative unsigned 64x64 -> 128-bit multiplier with stream handshakes.
// Four 64x16 partial products are accumulated over four cycles, one in flight at a time.
module mult_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  input_a_tdata,
  input  logic [63:0]  input_b_tdata,
  input  logic         input_a_tvalid,
  input  logic         input_b_tvalid,
  output logic         input_a_tready,
  output logic         input_b_tready,
  output logic [127:0] output_tdata,
  output logic         output_tvalid,
  input  logic         output_tready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_reg, state_next;
  logic [63:0]   a_reg, b_reg;
  logic [127:0]  acc_reg;
  logic [1:0]    cnt_reg;
  logic          ready_reg;
  logic [127:0]  tdata_reg;
  logic          tvalid_reg;

  logic [15:0]   b_chunk [4];
  logic [79:0]   pp;
  logic [127:0]  pp_shifted;
  logic [127:0]  acc_next;
  logic          capture;
  logic          transfer;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chunk
      assign b_chunk[gi] = b_reg[16*gi +: 16];
    end
  endgenerate

  assign pp         = {16'b0, a_reg} * {64'b0, b_chunk[cnt_reg]};
  assign pp_shifted = {48'b0, pp} << {cnt_reg, 4'b0000};
  assign acc_next   = acc_reg + pp_shifted;

  // Ready is registered so it stays low through reset and rises on the first edge after.
  assign capture  = ready_reg & input_a_tvalid & input_b_tvalid;
  assign transfer = tvalid_reg & output_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = CALC;
      CALC:    if (cnt_reg == 2'd3) state_next = DONE;
      DONE:    if (transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      ready_reg  <= 1'b0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end else begin
      ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (capture) begin
            a_reg   <= input_a_tdata;
            b_reg   <= input_b_tdata;
            acc_reg <= '0;
            cnt_reg <= '0;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            tdata_reg  <= acc_next;
            tvalid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (transfer) tvalid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign input_a_tready = ready_reg;
  assign input_b_tready = ready_reg;
  assign output_tdata   = tdata_reg;
  assign output_tvalid  = tvalid_reg;

endmodule

// File: tb/tb_mult_128.sv
// Directed bench for mult_128: expected products are queued at issue time and
// a monitor pops and compares them whenever a product is transferred.
module tb_mult_128;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  input_a_tdata = '0;
  logic [63:0]  input_b_tdata = '0;
  logic         input_a_tvalid = 1'b0;
  logic         input_b_tvalid = 1'b0;
  logic         input_a_tready;
  logic         input_b_tready;
  logic [127:0] output_tdata;
  logic         output_tvalid;
  logic         output_tready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [127:0] prev_data  = '0;

  always #5 clk = ~clk;

  mult_128 dut (
    .clk           (clk),
    .rst           (rst),
    .input_a_tdata (input_a_tdata),
    .input_b_tdata (input_b_tdata),
    .input_a_tvalid(input_a_tvalid),
    .input_b_tvalid(input_b_tvalid),
    .input_a_tready(input_a_tready),
    .input_b_tready(input_b_tready),
    .output_tdata  (output_tdata),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: compares every transferred product against the scoreboard and checks hold/ready rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      chk("ready_pair", {127'b0, input_a_tready}, {127'b0, input_b_tready});
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", {127'b0, output_tvalid}, 128'd1);
        chk("hold_data", output_tdata, prev_data);
      end
      if (output_tvalid && output_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_product: got=%h expected=none", output_tdata);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          chk("product", output_tdata, e);
          $display("xfer product=%h expected=%h", output_tdata, e);
        end
      end
      prev_valid <= output_tvalid;
      prev_ready <= output_tready;
      prev_data  <= output_tdata;
    end
  end

  // Present operands, wait (bounded) for the capture edge, then drop both valids.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [127:0] p);
    int t;
    input_a_tdata  = a;
    input_b_tdata  = b;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    exp_q.push_back(p);
    t = 0;
    @(negedge clk);
    while (!input_a_tready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("capture_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    input_a_tvalid = 1'b0;
    input_b_tvalid = 1'b0;
    $display("issue a=%h b=%h expect=%h", a, b, p);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", {127'b0, input_a_tready}, 128'd0);
    chk("rst_valid", {127'b0, output_tvalid}, 128'd0);
    chk("rst_data", output_tdata, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_before_edge", {127'b0, input_a_tready}, 128'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {127'b0, input_a_tready}, 128'd1);

    // Large operands, product held until consumer is ready
    output_tready = 1'b0;
    issue(64'd9223372036854775337, 64'd9223372036854775337,
          128'h3FFFFFFFFFFFFE29_0000000000036291);
    chk("ready_drop", {127'b0, input_a_tready}, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("valid_early", {127'b0, output_tvalid}, 128'd0);
    @(posedge clk); #1;
    chk("valid_at_4", {127'b0, output_tvalid}, 128'd1);
    chk("data_at_4", output_tdata, 128'h3FFFFFFFFFFFFE29_0000000000036291);
    repeat (5) @(posedge clk);
    #1;
    chk("ready_in_done", {127'b0, input_a_tready}, 128'd0);
    output_tready = 1'b1;
    @(posedge clk); #1;
    chk("valid_after_xfer", {127'b0, output_tvalid}, 128'd0);
    chk("data_retained", output_tdata, 128'h3FFFFFFFFFFFFE29_0000000000036291);
    chk("ready_back", {127'b0, input_a_tready}, 128'd1);
    drain();

    // All-ones operands with consumer always ready: valid lasts one cycle
    issue(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    repeat (4) @(posedge clk);
    #1;
    chk("ff_valid", {127'b0, output_tvalid}, 128'd1);
    @(posedge clk); #1;
    chk("ff_valid_1cyc", {127'b0, output_tvalid}, 128'd0);
    drain();

    // Zero and identity
    issue(64'd0, 64'h123456789ABCDEF0, 128'd0);
    drain();
    issue(64'd1, 64'h123456789ABCDEF0, 128'h0000000000000000_123456789ABCDEF0);
    drain();

    // Only A valid for 10 cycles: no capture
    input_a_tdata  = 64'd3;
    input_b_tdata  = 64'd5;
    input_a_tvalid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("one_valid_no_capture", {127'b0, input_a_tready}, 128'd1);
    issue(64'd3, 64'd5, 128'd15);
    drain();

    // Back-to-back with valids held high; A changes during CALC
    input_a_tdata  = 64'd2;
    input_b_tdata  = 64'd7;
    input_a_tvalid = 1'b1;
    input_b_tvalid = 1'b1;
    exp_q.push_back(128'd14);
    exp_q.push_back(128'd42);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!input_a_tready && t < 50) begin @(negedge clk); t++; end
      @(posedge clk); #1;
      input_a_tdata = 64'd6;
      $display("issue a=2 b=7 expect=14 (held valids)");
      chk("b2b_ready_calc", {127'b0, input_a_tready}, 128'd0);
      t = 0;
      @(negedge clk);
      while (!input_a_tready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("b2b_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
      input_a_tvalid = 1'b0;
      input_b_tvalid = 1'b0;
      input_a_tdata  = 64'hDEAD_BEEF_0000_1111;
      input_b_tdata  = 64'hFFFF_0000_FFFF_0000;
      $display("issue a=6 b=7 expect=42 (held valids)");
    end
    drain();

    // Async reset in the middle of CALC
    issue(64'd11, 64'd13, 128'd143);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {127'b0, output_tvalid}, 128'd0);
    chk("abort_data", output_tdata, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {127'b0, input_a_tready}, 128'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_stale", {127'b0, output_tvalid}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mult_128.md
Name: mult_128

Overview:
- Unsigned 64x64 -> 128-bit multiplier with stream-style valid/ready handshakes on two operand inputs and one product output.
- Serves as the wide-multiply primitive for the ElGamal modular arithmetic datapath (modular multiply/exponentiation stages feed it operands and consume products).
- Iterative: one operation in flight, fixed compute latency, product held until consumed.

Parameters:
- none (widths fixed: operands 64 bits, product 128 bits; 4 iterations of a 64x16 partial product)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- input_a_tdata  input  64  operand A, unsigned
- input_b_tdata  input  64  operand B, unsigned
- input_a_tvalid  input  1  operand A valid
- input_b_tvalid  input  1  operand B valid
- input_a_tready  output  1  block can accept operand A
- input_b_tready  output  1  block can accept operand B
- output_tdata  output  128  product A*B
- output_tvalid  output  1  product valid
- output_tready  input  1  downstream accepts product

Behaviour:
- Reset (async, rst=1): state=IDLE, input_a_tready=input_b_tready=0 while rst high, output_tvalid=0, output_tdata=0, internal operand/accumulator/counter registers=0. After rst deasserts, readies rise at the first clock edge (IDLE).
- Both readies are always identical. They are 1 only in IDLE.
- States: IDLE, CALC, DONE.
- IDLE: readies=1. Joint handshake: operands are captured only on an edge where input_a_tvalid & input_b_tvalid & ready are all 1. Both operands transfer together. If only one valid is high, nothing is captured and readies stay 1. On capture: latch A and B, clear the accumulator, counter=0, go to CALC, readies drop to 0.
- CALC: each cycle, acc += A * B[16k+15:16k] << 16k, for k = counter (0..3), then counter++.
  - After k=3, load output_tdata with the final sum, assert output_tvalid=1, go to DONE.
  - output_tvalid rises exactly 4 clock edges after the capture edge.
- DONE: output_tdata and output_tvalid are held stable while output_tready=0, with no timeout.
  - On an edge with output_tvalid & output_tready: output_tvalid=0, go to IDLE. output_tdata retains its last value after the transfer.
  - If output_tready is already 1 when output_tvalid rises, the transfer happens on the next edge (valid is high for exactly 1 cycle).
- Throughput: readies are 0 during CALC/DONE. The next capture is possible at the earliest on the edge after returning to IDLE, i.e. at least 6 cycles per operation.
- Input tdata changes while not in IDLE are ignored, because the operands are latched.
- Arithmetic: full unsigned product, no truncation. The 128-bit accumulator never overflows (max (2^64-1)^2 < 2^128). Each partial product is 80 bits, zero-extended.
- Reset mid-operation (CALC or DONE) aborts the operation immediately: output_tvalid=0, output_tdata=0, state IDLE. No partial result is emitted.
- Input valid X/0 before the first handshake must not cause a capture; capture requires both valids to be 1.

Test Plan:
- Reset: assert rst mid-CALC -> output_tvalid=0 and output_tdata=0 immediately (async); after release, readies=1 on the next edge and no stale result appears.
- A=B=64'd9223372036854775337, both valids 1, output_tready=0 initially, raised later -> readies drop after the capture edge; output_tvalid rises 4 edges after capture; output_tdata=128'h3FFFFFFFFFFFFE29_0000000000036291 held until output_tready=1, then output_tvalid=0 on the next edge.
- A=B=64'hFFFFFFFFFFFFFFFF, output_tready held 1 -> output_tdata=128'hFFFFFFFFFFFFFFFE_0000000000000001, output_tvalid high exactly 1 cycle.
- A=0, B=64'h123456789ABCDEF0 -> product 0. Then A=1, B=64'h123456789ABCDEF0 -> output_tdata=128'h0000000000000000_123456789ABCDEF0.
- Only input_a_tvalid=1 for 10 cycles, then input_b_tvalid=1 (A=3, B=5) -> no capture until both are high; result 128'd15.
- Back-to-back: both valids held high continuously with output_tready=1, A=2/B=7 then A=6/B=7 -> products 14 then 42, in order; readies re-assert only in IDLE; operand changes during CALC do not corrupt results.
